// File: rtl/paddsb_serial_pkg.sv
// Shared types and constants for the serial packed saturating-add engine.
// Holds the FSM state encoding, lane width and saturation values.
package paddsb_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int LANE_W = 4;

    localparam logic [3:0] SAT_POS = 4'b0111;
    localparam logic [3:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/paddsb_serial_nibble_sat_add.sv
// Combinational 4-bit ripple adder with signed saturation.
// Overflow is the carry into the sign bit XOR the carry out of it.
module nibble_sat_add
    import paddsb_serial_pkg::*;
(
    output logic [3:0] Sum,
    output logic       Overflow,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CarryIn
);

    logic [4:0] carry;
    logic [3:0] raw;

    always_comb begin
        carry[0] = CarryIn;
        raw      = '0;
        for (int i = 0; i < 4; i++) begin
            raw[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        Overflow = carry[3] ^ carry[4];
        if (Overflow) begin
            Sum = A[3] ? SAT_NEG : SAT_POS;
        end else begin
            Sum = raw;
        end
    end

endmodule

// File: rtl/paddsb_serial.sv
// Serial PADDSB engine: one shared saturating nibble adder, one lane per cycle.
// Optional sticky overflow flag is enabled by defining PADDSB_STICKY_OVF_EN.
module paddsb_serial
    import paddsb_serial_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
`ifdef PADDSB_STICKY_OVF_EN
    input  logic                    clr_sticky,
    output logic                    ovf_sticky,
`endif
    input  logic [4*NIBBLES-1:0]    A,
    input  logic [4*NIBBLES-1:0]    B,
    output logic [4*NIBBLES-1:0]    Sum,
    output logic [NIBBLES-1:0]      Ovf,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int W  = LANE_W * NIBBLES;

    state_t          state;
    state_t          nextState;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    opA;
    logic [W-1:0]    opB;
    logic [3:0]      aLane;
    logic [3:0]      bLane;
    logic [3:0]      laneSum;
    logic            laneOvf;
    logic            accept;
    logic            lastLane;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign lastLane = (cnt == CW'(NIBBLES - 1));
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        aLane = '0;
        bLane = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                aLane = opA[i*LANE_W +: LANE_W];
                bLane = opB[i*LANE_W +: LANE_W];
            end
        end
    end

    nibble_sat_add uAdd (
        .Sum      (laneSum),
        .Overflow (laneOvf),
        .A        (aLane),
        .B        (bLane),
        .CarryIn  (1'b0)
    );

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (lastLane) nextState = DONE;
            DONE:    nextState = start ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            opA   <= '0;
            opB   <= '0;
            Sum   <= '0;
            Ovf   <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                opA <= A;
                opB <= B;
                Sum <= '0;
                Ovf <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt == CW'(i)) begin
                        Sum[i*LANE_W +: LANE_W] <= laneSum;
                        Ovf[i]                  <= laneOvf;
                    end
                end
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef PADDSB_STICKY_OVF_EN
    // Clear has priority over a same-cycle saturating lane write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end else if ((state == RUN) && laneOvf) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule
